// File: rtl/br_pred_gshare.sv
// gshare branch direction predictor: counter table indexed by address XOR speculative GHR, trained at commit.
// Global history is enabled by defining BR_PRED_GHIST_EN; otherwise the table is indexed bimodally.
module br_pred_gshare #(
  parameter int unsigned ADDR     = 32,
  parameter int unsigned CNTW     = 2,
  parameter int unsigned PRED_D   = 8,
  parameter int unsigned PRT_D    = 256,
  parameter int unsigned GHR_W    = 8,
  parameter int unsigned SIMBRF   = 2,
  parameter int unsigned SIMBRCOM = 2,
  parameter bit          OUTREG   = 1'b1,
  parameter int unsigned INST_W   = 32,
  parameter int unsigned BYTE_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush_,
  input  logic [SIMBRF-1:0]        br_,
  input  logic [SIMBRF*ADDR-1:0]   br_addr,
  output logic [SIMBRF-1:0]        pred_taken,
  input  logic [SIMBRCOM-1:0]      br_commit_,
  input  logic [SIMBRCOM-1:0]      br_taken_,
  input  logic [SIMBRCOM-1:0]      br_pred_miss_,
  output logic                     busy
);

  localparam int unsigned TBL_IDX  = $clog2(PRT_D);
  localparam int unsigned ADDR_OFS = $clog2(INST_W / BYTE_W);
  localparam int unsigned PTR_W    = $clog2(PRED_D);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [CNTW-1:0] RST_CNT = CNTW'(1) << (CNTW - 1);

  logic [CNTW-1:0]     ctr     [PRT_D];
  logic [TBL_IDX-1:0]  rec_mem [PRED_D];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, wr_n, rd_n;
  logic [CNT_W-1:0]    occ, occ_n;
  logic                busy_n;

  logic [TBL_IDX-1:0]  pidx     [SIMBRF];
  logic [PTR_W-1:0]    push_ptr [SIMBRF];
  logic [SIMBRF-1:0]   pred_c;
  logic [SIMBRF-1:0]   push_en;
  logic [CNT_W-1:0]    n_push;

  logic [SIMBRCOM-1:0] tr_en;
  logic [TBL_IDX-1:0]  tr_idx [SIMBRCOM];
  logic [CNTW-1:0]     tr_val [SIMBRCOM];
  logic [CNT_W-1:0]    n_pop;
  logic                miss;
  logic                recover;

  logic                unused_addr;
  assign unused_addr = ^br_addr;

  function automatic logic [CNTW-1:0] sat_step(input logic [CNTW-1:0] v, input logic up);
    logic [CNTW-1:0] r;
    r = v;
    if (up) begin
      if (v != {CNTW{1'b1}}) r = v + CNTW'(1);
    end else begin
      if (v != '0) r = v - CNTW'(1);
    end
    return r;
  endfunction

  // Commit lanes pop records in order; lanes after a mispredicted one are dropped.
  always_comb begin
    logic [SIMBRCOM-1:0] en;
    logic [TBL_IDX-1:0]  idx [SIMBRCOM];
    logic [CNTW-1:0]     v;
    en    = '0;
    v     = '0;
    miss  = 1'b0;
    n_pop = '0;
    for (int j = 0; j < int'(SIMBRCOM); j++) begin
      idx[j] = rec_mem[rd_ptr + PTR_W'(n_pop)];
      en[j]  = !br_commit_[j] && !miss;
      v      = ctr[idx[j]];
      // Earlier lanes hitting the same entry accumulate before this lane's step.
      for (int k = 0; k <= j; k++) begin
        if (en[k] && (idx[k] == idx[j])) v = sat_step(v, !br_taken_[k]);
      end
      tr_idx[j] = idx[j];
      tr_val[j] = v;
      if (en[j]) begin
        n_pop = n_pop + CNT_W'(1);
        miss  = !br_pred_miss_[j];
      end
    end
    tr_en = en;
  end

  assign recover = miss || !flush_;

`ifdef BR_PRED_GHIST_EN
  logic [GHR_W-1:0] spec_ghr, arch_ghr, h_run, arch_run;

  // Architectural history advances with each surviving commit lane's outcome.
  always_comb begin
    arch_run = arch_ghr;
    for (int j = 0; j < int'(SIMBRCOM); j++) begin
      if (tr_en[j]) arch_run = GHR_W'({arch_run, !br_taken_[j]});
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
    end else begin
      arch_ghr <= arch_run;
      spec_ghr <= recover ? arch_run : h_run;
    end
  end
`else
  logic [GHR_W-1:0] unused_ghr;
  assign unused_ghr = '0;
`endif

  // Prediction lanes are serial: each active lane folds its prediction into the next lane's history.
  always_comb begin
    logic p;
    p      = 1'b0;
    n_push = '0;
`ifdef BR_PRED_GHIST_EN
    h_run  = spec_ghr;
`endif
    for (int i = 0; i < int'(SIMBRF); i++) begin
`ifdef BR_PRED_GHIST_EN
      pidx[i] = br_addr[i*ADDR + ADDR_OFS +: TBL_IDX] ^ TBL_IDX'(h_run);
`else
      pidx[i] = br_addr[i*ADDR + ADDR_OFS +: TBL_IDX];
`endif
      p           = ctr[pidx[i]][CNTW-1];
      pred_c[i]   = p;
      push_en[i]  = !br_[i] && !recover;
      push_ptr[i] = wr_ptr + PTR_W'(n_push);
      if (push_en[i]) n_push = n_push + CNT_W'(1);
`ifdef BR_PRED_GHIST_EN
      if (!br_[i]) h_run = GHR_W'({h_run, p});
`endif
    end
  end

  always_comb begin
    wr_n  = wr_ptr + PTR_W'(n_push);
    rd_n  = rd_ptr + PTR_W'(n_pop);
    occ_n = occ + n_push - n_pop;
    if (recover) begin
      wr_n  = '0;
      rd_n  = '0;
      occ_n = '0;
    end
    busy_n = (32'(occ_n) + SIMBRF) > PRED_D;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      busy   <= 1'b0;
    end else begin
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      occ    <= occ_n;
      busy   <= busy_n;
    end
  end

  // Record storage needs no reset: entries are only read after being pushed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(SIMBRF); i++) begin
      if (push_en[i]) rec_mem[push_ptr[i]] <= pidx[i];
    end
  end

  // Later lanes overwrite earlier ones; their value already includes the earlier steps.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int e = 0; e < int'(PRT_D); e++) ctr[e] <= RST_CNT;
    end else begin
      for (int j = 0; j < int'(SIMBRCOM); j++) begin
        if (tr_en[j]) ctr[tr_idx[j]] <= tr_val[j];
      end
    end
  end

  generate
    if (OUTREG) begin : g_outreg
      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) pred_taken <= '0;
        else         pred_taken <= pred_c;
      end
    end else begin : g_outcomb
      assign pred_taken = pred_c;
    end
  endgenerate

endmodule

// File: tb/tb_br_pred_gshare.sv
// Self-checking bench for br_pred_gshare against a table/queue reference model.
// Follows BR_PRED_GHIST_EN the same way as the design (gshare when defined, bimodal otherwise).
`timescale 1ns/1ps
module tb_br_pred_gshare;

  localparam int PRED_D = 8;
  localparam int PRT_D  = 256;
  localparam int GHR_W  = 8;
  localparam int NF     = 2;
  localparam int CNTW   = 2;
`ifdef BR_PRED_GHIST_EN
  localparam bit GH = 1'b1;
`else
  localparam bit GH = 1'b0;
`endif
  localparam int GMASK = (1 << GHR_W) - 1;
  localparam int CMAX  = (1 << CNTW) - 1;
  localparam int WEAK  = 1 << (CNTW - 1);

  logic        clk = 1'b0;
  logic        reset_;
  logic        flush_;
  logic [1:0]  br_;
  logic [63:0] br_addr;
  logic [1:0]  pred_taken;
  logic [1:0]  br_commit_;
  logic [1:0]  br_taken_;
  logic [1:0]  br_pred_miss_;
  logic        busy;

  br_pred_gshare #(
    .ADDR(32), .CNTW(CNTW), .PRED_D(PRED_D), .PRT_D(PRT_D), .GHR_W(GHR_W),
    .SIMBRF(2), .SIMBRCOM(2), .OUTREG(1'b1)
  ) dut (
    .clk(clk), .reset_(reset_), .flush_(flush_), .br_(br_), .br_addr(br_addr),
    .pred_taken(pred_taken), .br_commit_(br_commit_), .br_taken_(br_taken_),
    .br_pred_miss_(br_pred_miss_), .busy(busy)
  );

  always #5 clk = ~clk;

  int   tbl [PRT_D];
  int   q [$];
  int   m_spec, m_arch;
  bit   m_busy;
  logic [1:0] exp_pred, exp_act;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic idle_inputs();
    br_ = 2'b11; br_commit_ = 2'b11; br_taken_ = 2'b11; br_pred_miss_ = 2'b11;
    flush_ = 1'b1; br_addr = '0;
  endtask

  task automatic model_reset();
    for (int e = 0; e < PRT_D; e++) tbl[e] = WEAK;
    q.delete();
    m_spec = 0; m_arch = 0; m_busy = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset_ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_ = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] addr_for(input int idx, input int h);
    logic [31:0] a;
    a = 32'((idx ^ h) & (PRT_D - 1)) << 2;
    return a;
  endfunction

  // One clock of stimulus; the model predicts from pre-edge state, then applies training and recovery.
  task automatic step(input logic [1:0] br, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [1:0] cm, input logic [1:0] tk, input logic [1:0] ms,
                      input logic fl);
    int h, a, idx;
    int pi [2];
    bit stop, rec;
    logic [31:0] ad [2];
    ad[0] = a0; ad[1] = a1;
    br_ = ~br; br_addr = {a1, a0}; br_commit_ = ~cm; br_taken_ = ~tk;
    br_pred_miss_ = ~ms; flush_ = ~fl;
    h = m_spec;
    for (int i = 0; i < NF; i++) begin
      pi[i] = int'((ad[i] >> 2) % PRT_D) ^ h;
      exp_pred[i] = (tbl[pi[i]] >= WEAK);
      if (br[i] && GH) h = ((h << 1) | int'(exp_pred[i])) & GMASK;
    end
    a = m_arch; stop = 1'b0; rec = fl;
    for (int j = 0; j < 2; j++) begin
      if (cm[j] && !stop) begin
        idx = q.pop_front();
        if (tk[j]) tbl[idx] = (tbl[idx] < CMAX) ? tbl[idx] + 1 : CMAX;
        else       tbl[idx] = (tbl[idx] > 0) ? tbl[idx] - 1 : 0;
        if (GH) a = ((a << 1) | int'(tk[j])) & GMASK;
        if (ms[j]) begin stop = 1'b1; rec = 1'b1; end
      end
    end
    if (rec) q.delete();
    else for (int i = 0; i < NF; i++) if (br[i]) q.push_back(pi[i]);
    m_arch = a;
    m_spec = rec ? a : h;
    m_busy = (PRED_D - q.size()) < NF;
    exp_act = br;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_ = 1'b0;
    #12;
    n_tests++;
    if (pred_taken !== 2'b00) begin n_fail++; $display("FAIL reset_pred: got %b want 00", pred_taken); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk) reset_ = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      step(2'b01, 32'h100, 32'h0, 2'b00, 2'b00, 2'b00, 1'b0);
      n_tests++;
      if (pred_taken[0] !== exp_pred[0]) begin
        n_fail++; $display("FAIL reset_first_pred s%0d: got %b want %b", s, pred_taken[0], exp_pred[0]);
      end
      if (s == 0) begin
        n_tests++;
        if (pred_taken[0] !== 1'b1) begin n_fail++; $display("FAIL reset_weak_taken: got %b want 1", pred_taken[0]); end
      end
    end
  endtask

  task automatic test_dual_lane();
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: step(2'b11, 32'h200, 32'h300, 2'b00, 2'b00, 2'b00, 1'b0);
        1: step(2'b00, 32'h0,   32'h0,   2'b11, 2'b00, 2'b00, 1'b0);
        2: step(2'b11, 32'h200, 32'h300, 2'b00, 2'b00, 2'b00, 1'b0);
        3: step(2'b10, 32'h204, 32'h200, 2'b01, 2'b00, 2'b00, 1'b0);
        4: step(2'b11, 32'h300, 32'h200, 2'b11, 2'b11, 2'b00, 1'b0);
        default: step(2'b11, 32'h200, 32'h300, 2'b01, 2'b01, 2'b00, 1'b0);
      endcase
      for (int i = 0; i < 2; i++) if (exp_act[i]) begin
        n_tests++;
        if (pred_taken[i] !== exp_pred[i]) begin
          n_fail++; $display("FAIL dual_pred s%0d lane%0d: got %b want %b", s, i, pred_taken[i], exp_pred[i]);
        end
      end
      n_tests++;
      if (busy !== m_busy) begin n_fail++; $display("FAIL dual_busy s%0d: got %b want %b", s, busy, m_busy); end
    end
  endtask

  task automatic test_saturate();
    int tgt, h0, h1;
    tgt = 8'h55;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      h0 = m_spec;
      h1 = GH ? (((h0 << 1) | int'(tbl[tgt] >= WEAK)) & GMASK) : 0;
      step(2'b11, addr_for(tgt, h0), addr_for(tgt, h1), 2'b00, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (pred_taken[i] !== exp_pred[i]) begin
          n_fail++; $display("FAIL sat_pred r%0d lane%0d: got %b want %b", r, i, pred_taken[i], exp_pred[i]);
        end
      end
      step(2'b00, 32'h0, 32'h0, 2'b11, 2'b00, 2'b00, 1'b0);
    end
    step(2'b01, addr_for(tgt, m_spec), 32'h0, 2'b00, 2'b00, 2'b00, 1'b0);
    n_tests++;
    if (pred_taken[0] !== 1'b0) begin n_fail++; $display("FAIL sat_floor: got %b want 0", pred_taken[0]); end
  endtask

  task automatic test_miss();
    apply_reset();
    step(2'b11, 32'h100, 32'h140, 2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b01, 32'h180, 32'h0,   2'b00, 2'b00, 2'b00, 1'b0);
    step(2'b00, 32'h0,   32'h0,   2'b11, 2'b00, 2'b01, 1'b0);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL miss_busy: got %b want 0", busy); end
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: step(2'b11, 32'h100, 32'h140, 2'b00, 2'b00, 2'b00, 1'b0);
        1: step(2'b01, 32'h180, 32'h0,   2'b11, 2'b10, 2'b00, 1'b0);
        2: step(2'b11, 32'h100, 32'h180, 2'b01, 2'b00, 2'b00, 1'b0);
        default: step(2'b01, 32'h140, 32'h0, 2'b11, 2'b01, 2'b10, 1'b0);
      endcase
      for (int i = 0; i < 2; i++) if (exp_act[i]) begin
        n_tests++;
        if (pred_taken[i] !== exp_pred[i]) begin
          n_fail++; $display("FAIL miss_pred s%0d lane%0d: got %b want %b", s, i, pred_taken[i], exp_pred[i]);
        end
      end
    end
  endtask

  task automatic test_busy_flush();
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      step((s < 3) ? 2'b11 : 2'b01, 32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2,
           2'b00, 2'b00, 2'b00, 1'b0);
      n_tests++;
      if (busy !== ((s < 3) ? 1'b0 : 1'b1)) begin
        n_fail++; $display("FAIL busy_fill s%0d: got %b want %b", s, busy, (s >= 3));
      end
    end
    step(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, 1'b1);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_flush: got %b want 0", busy); end
    step(2'b11, 32'h100, 32'h104, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (pred_taken[i] !== exp_pred[i]) begin
        n_fail++; $display("FAIL flush_pred lane%0d: got %b want %b", i, pred_taken[i], exp_pred[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] br, cm, tk, ms;
    int nc, lim;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      br  = m_busy ? 2'b00 : 2'($urandom_range(0, 3));
      lim = (q.size() < 2) ? q.size() : 2;
      nc  = $urandom_range(0, lim);
      cm  = (nc == 0) ? 2'b00 : ((nc == 1) ? 2'b01 : 2'b11);
      tk  = 2'($urandom_range(0, 3));
      ms  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      step(br, 32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2,
           cm, tk, ms, ($urandom_range(0, 39) == 0));
      for (int i = 0; i < 2; i++) if (exp_act[i]) begin
        n_tests++;
        if (pred_taken[i] !== exp_pred[i]) begin
          n_fail++; $display("FAIL rand_pred c%0d lane%0d: got %b want %b", c, i, pred_taken[i], exp_pred[i]);
        end
      end
      n_tests++;
      if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_busy); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 12; c++) begin
      step(m_busy ? 2'b00 : 2'b11, 32'($urandom_range(0, 63)) << 2, 32'($urandom_range(0, 63)) << 2,
           (q.size() >= 2) ? 2'b11 : 2'b00, 2'b00, 2'b00, 1'b0);
    end
    step(m_busy ? 2'b00 : 2'b11, 32'h100, 32'h104, 2'b00, 2'b00, 2'b00, 1'b0);
    #3 reset_ = 1'b0;
    #1;
    n_tests++;
    if (pred_taken !== 2'b00) begin n_fail++; $display("FAIL midreset_pred: got %b want 00", pred_taken); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(negedge clk) reset_ = 1'b1;
    model_reset();
    @(posedge clk); #1;
    step(2'b11, 32'($urandom_range(0, 255)) << 2, 32'($urandom_range(0, 255)) << 2, 2'b00, 2'b00, 2'b00, 1'b0);
    n_tests++;
    if (pred_taken !== 2'b11) begin n_fail++; $display("FAIL midreset_weak: got %b want 11", pred_taken); end
  endtask

  initial begin
    idle_inputs();
    reset_ = 1'b1;
    test_reset();
    test_dual_lane();
    test_saturate();
    test_miss();
    test_busy_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/br_pred_gshare.md
# br_pred_gshare

Parametrised successor to the per-address bimodal counter predictor. It indexes the saturating-counter table with the branch address XORed with a speculative global history register (GHR). It keeps a committed (architectural) GHR and recovers the speculative GHR on misprediction or flush. It sits in the fetch stage beside the BTB and is trained from the commit stage; up to SIMBRF predictions and SIMBRCOM trainings occur per cycle.

## Interface
- ADDR, `AddrWidth: branch address width
- CNTW, `PredCntWidth: saturating counter width (≥1)
- PRED_D, `PredMaxDepth: in-flight prediction record depth (power of 2)
- PRT_D, `PredTableDepth: counter table depth (power of 2); TBL_IDX = log2(PRT_D)
- GHR_W, 8: global history length, 1..TBL_IDX
- SIMBRF, `SimBrFetch: prediction lanes per cycle
- SIMBRCOM, `SimBrCommit: training lanes per cycle
- OUTREG, `Enable: register pred_taken
- clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- flush_  in  1  active-low pipeline flush
- br_  in  SIMBRF  active-low per-lane prediction request
- br_addr  in  SIMBRF*ADDR  per-lane branch address, lane i at [i*ADDR +: ADDR]
- pred_taken  out  SIMBRF  prediction, 1 = taken
- br_commit_  in  SIMBRCOM  active-low commit of the oldest in-flight branches, in order
- br_taken_  in  SIMBRCOM  active-low actual outcome per committed lane
- br_pred_miss_  in  SIMBRCOM  active-low misprediction flag per committed lane
- busy  out  1  high when free record entries < SIMBRF

## Operation
- Index, lane i: addr[TBL_IDX+ADDR_OFS-1:ADDR_OFS] XOR zero-extended h_i, where ADDR_OFS = log2(`InstWidth/`ByteBitWidth).
- h_0 = spec GHR. h_{i+1} = {h_i[GHR_W-2:0], pred_i} if lane i is active, else h_i. Lanes are serial within the cycle, lane 0 oldest.
- Prediction is the counter MSB. Spec GHR ← h_SIMBRF at the clock edge.
- Record FIFO (fifo_mRnW, ACT Low): each active lane pushes its TBL_IDX index. br_commit_ pops the records in the same lane order.
- Training, committed lane j: counter[idx_j] increments (saturating at 2^CNTW-1) if taken, else decrements (saturating at 0).
- Training lanes apply serially. Several lanes hitting one index accumulate, e.g. +1 then +1 gives +2.
- Arch GHR shifts in each committed lane's actual outcome, lane 0 first.
- Misprediction on committed lane j:
  - lanes 0..j train normally;
  - lanes >j in the same cycle are ignored (no pop, no train);
  - the record FIFO is cleared;
  - spec GHR ← arch GHR updated through lane j.
- flush_ low: record FIFO cleared; spec GHR ← arch GHR including this cycle's commits. Training in the same cycle still applies.
- Predictions in a recovery or flush cycle are neither recorded nor folded into the GHR. pred_taken is still driven.
- Active lanes while busy is high are undefined. Upstream stalls on busy.

## Timing
- Reset: every counter = 2^(CNTW-1) (weakly taken); both GHRs = 0; FIFO empty; pred_taken = 0; busy = 0.
- OUTREG=1: pred_taken is valid one cycle after br_. OUTREG=0: combinational, same cycle.
- A training edge is visible to predictions from the next cycle. Same-cycle predict and train reads the pre-update counter.
- GHR update from predictions or recovery is visible the next cycle.
- busy is a registered function of FIFO occupancy. After any flush or miss, it deasserts the following cycle.
- Reset mid-operation clears all state asynchronously. No partial training survives.

## Configuration
- BR_PRED_GHIST_EN defined: gshare behaviour as above.
- BR_PRED_GHIST_EN undefined:
  - both GHRs are tied to 0, so index = address bits only (bimodal);
  - recovery only clears the record FIFO;
  - GHR_W is ignored;
  - all other timing is identical.

## Test plan
Defaults for all scenarios: CNTW=2, PRT_D=256, GHR_W=8, SIMBRF=2, SIMBRCOM=2, PRED_D=8, OUTREG=1, BR_PRED_GHIST_EN defined.
- Reset, then predict addr 0x100 → pred_taken[0]=1 one cycle later; counter 2; spec GHR then 0x01.
- Lane 0 and lane 1 both active, lane 0 predicted taken → lane 1 index uses h_1=0x01; spec GHR advances by 2 bits to 0x03.
- Commit two not-taken branches sharing an index with counter 2 in one cycle → counter 0; a second such cycle keeps it at 0 (saturation).
- Three predictions (spec GHR 0x07), then commit lane 0 with a miss (actual not-taken) and lane 1 also asserted → lane 1 ignored; FIFO empty; spec GHR = arch = 0x00 next cycle.
- Fill 7 records → busy=1; flush_ low for one cycle → busy=0 and spec GHR = arch GHR the following cycle.
- BR_PRED_GHIST_EN undefined: predict 0x100 after varied history → the same counter is always indexed; table state matches the bimodal model.
